// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: per-pin synchroniser + debounce, W1C edge capture and a maskable edge IRQ.
// Optional GPIO_COND_GLITCH_CNT_EN adds a saturating aborted-debounce counter at address 4.

module gpio_in_cond_lane #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_COUNT    = 4,
    parameter logic RESET_BIT   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin_i,
    input  logic tick_i,
    input  logic bypass_i,
    output logic clean_o,
    output logic edge_o
`ifdef GPIO_COND_GLITCH_CNT_EN
    ,
    output logic abort_o
`endif
);
    localparam int            CW       = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= {SYNC_STAGES{RESET_BIT}};
            cnt_q   <= '0;
            clean_q <= RESET_BIT;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    // A new level must be seen on DB_COUNT consecutive ticks; any return to the clean level restarts.
    always_comb begin
        clean_d = clean_q;
        cnt_d   = cnt_q;
        if (bypass_i) begin
            clean_d = s;
            cnt_d   = '0;
        end else if (s == clean_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = s;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign clean_o = clean_q;
    assign edge_o  = clean_d ^ clean_q;
`ifdef GPIO_COND_GLITCH_CNT_EN
    assign abort_o = ~bypass_i & (s == clean_q) & (cnt_q != '0);
`endif
endmodule

module gpio_in_conditioner #(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter int               PRESCALE    = 100,
    parameter int               DB_COUNT    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] clean_out,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             edge_irq
);
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre_q, pre_d;
    logic             tick;
    logic [WIDTH-1:0] clean, edges;
    logic [WIDTH-1:0] cap_q, cap_d, mask_q, mask_d, byp_q, byp_d;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_q, rd_d;
    logic             irq_q, irq_d;
    logic             wr_en;

    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + 1'b1;
    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

`ifdef GPIO_COND_GLITCH_CNT_EN
    logic [WIDTH-1:0] abort;
    logic [15:0]      glitch_q, glitch_d;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        gpio_in_cond_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_COUNT    (DB_COUNT),
            .RESET_BIT   (RESET_VAL[i])
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .pin_i    (pin_in[i]),
            .tick_i   (tick),
            .bypass_i (byp_q[i]),
            .clean_o  (clean[i]),
            .edge_o   (edges[i])
`ifdef GPIO_COND_GLITCH_CNT_EN
            ,
            .abort_o  (abort[i])
`endif
        );
    end

    // Capture set has priority over a same-cycle W1C clear so no edge is ever lost.
    always_comb begin
        cap_d  = cap_q;
        mask_d = mask_q;
        byp_d  = byp_q;
        if (wr_en && address == 3'd1) cap_d = cap_q & ~wdata;
        if (wr_en && address == 3'd2) mask_d = wdata;
        if (wr_en && address == 3'd3) byp_d = wdata;
        cap_d = cap_d | edges;
        irq_d = |(cap_q & mask_q);
    end

`ifdef GPIO_COND_GLITCH_CNT_EN
    always_comb begin
        glitch_d = glitch_q;
        if (wr_en && address == 3'd4)
            glitch_d = '0;
        else if (|abort && glitch_q != 16'hFFFF)
            glitch_d = glitch_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) glitch_q <= '0;
        else          glitch_q <= glitch_d;
    end
`endif

    always_comb begin
        rd_d = '0;
        case (address)
            3'd0: rd_d[WIDTH-1:0] = clean;
            3'd1: rd_d[WIDTH-1:0] = cap_q;
            3'd2: rd_d[WIDTH-1:0] = mask_q;
            3'd3: rd_d[WIDTH-1:0] = byp_q;
`ifdef GPIO_COND_GLITCH_CNT_EN
            3'd4: rd_d[15:0] = glitch_q;
`endif
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            cap_q  <= '0;
            mask_q <= '0;
            byp_q  <= '0;
            rd_q   <= '0;
            irq_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cap_q  <= cap_d;
            mask_q <= mask_d;
            byp_q  <= byp_d;
            rd_q   <= rd_d;
            irq_q  <= irq_d;
        end
    end

    assign clean_out = clean;
    assign readdata  = rd_q;
    assign edge_irq  = irq_q;
endmodule
